// File: rtl/fft_bitrev_loader.sv
// Bit-reversal frame loader: walks the bit-reversal ROM pair by pair and
// copies the addressed samples in ascending order into FFT working RAM.
module fft_bitrev_loader #(
    parameter int DATA_W  = 16,
    parameter int ROM_AW  = 9,
    parameter int SAMP_AW = 10
) (
    input  logic               Clk,
    input  logic               Resetn,
    input  logic               Start,
    input  logic               Abort,
    output logic               Busy,
    output logic               Done,
    output logic [ROM_AW-1:0]  RomAddr,
    input  logic [SAMP_AW-1:0] RomDoutA,
    input  logic [SAMP_AW-1:0] RomDoutB,
    output logic [SAMP_AW-1:0] SampRdAddr,
    input  logic [DATA_W-1:0]  SampRdData,
    output logic               FftWrEn,
    output logic [SAMP_AW-1:0] FftWrAddr,
    output logic [DATA_W-1:0]  FftWrData
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ROM,
        S_SELA,
        S_SELB,
        S_WRB,
        S_DONE
    } state_t;

    state_t              state_q, state_d;
    logic [ROM_AW-1:0]   k_q, k_d;
    logic [SAMP_AW-1:0]  regb_q, regb_d;
    logic [SAMP_AW-1:0]  raddr_q;

    always_ff @(posedge Clk or negedge Resetn) begin
        if (!Resetn) begin
            state_q <= S_IDLE;
            k_q     <= '0;
            regb_q  <= '0;
            raddr_q <= '0;
        end else begin
            state_q <= state_d;
            k_q     <= k_d;
            regb_q  <= regb_d;
            raddr_q <= SampRdAddr;
        end
    end

    assign RomAddr = k_q;

    always_comb begin
        state_d    = state_q;
        k_d        = k_q;
        regb_d     = regb_q;
        Busy       = (state_q != S_IDLE);
        Done       = 1'b0;
        FftWrEn    = 1'b0;
        FftWrAddr  = '0;
        FftWrData  = '0;
        // read address is held outside the two select cycles
        SampRdAddr = raddr_q;

        unique case (state_q)
            S_IDLE: begin
                if (Start && !Abort) begin
                    state_d = S_ROM;
                    k_d     = '0;
                end
            end
            S_ROM: begin
                state_d = S_SELA;
            end
            S_SELA: begin
                SampRdAddr = RomDoutA;
                regb_d     = RomDoutB;
                state_d    = S_SELB;
            end
            S_SELB: begin
                SampRdAddr = regb_q;
                FftWrEn    = 1'b1;
                FftWrAddr  = {k_q, 1'b0};
                FftWrData  = SampRdData;
                state_d    = S_WRB;
            end
            S_WRB: begin
                FftWrEn   = 1'b1;
                FftWrAddr = {k_q, 1'b1};
                FftWrData = SampRdData;
                if (k_q == {ROM_AW{1'b1}}) begin
                    state_d = S_DONE;
                end else begin
                    k_d     = k_q + 1'b1;
                    state_d = S_ROM;
                end
            end
            S_DONE: begin
                Done    = 1'b1;
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // abort overrides every transition, including the final WRB->DONE
        if (Abort && (state_q != S_IDLE)) begin
            state_d = S_IDLE;
            k_d     = '0;
        end
    end

endmodule

// File: tb/tb_fft_bitrev_loader.sv
// Scoreboard bench for fft_bitrev_loader with behavioural ROM and
// sample buffer models; every write is matched against a queued expectation.
module tb_fft_bitrev_loader;

    localparam int DW = 16;
    localparam int RW = 9;
    localparam int SW = 10;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          start;
    logic          abort;
    logic          busy;
    logic          done;
    logic [RW-1:0] rom_addr;
    logic [SW-1:0] rom_a;
    logic [SW-1:0] rom_b;
    logic [SW-1:0] rd_addr;
    logic [DW-1:0] rd_data;
    logic          wr_en;
    logic [SW-1:0] wr_addr;
    logic [DW-1:0] wr_data;

    always #5 clk = ~clk;

    fft_bitrev_loader #(.DATA_W(DW), .ROM_AW(RW), .SAMP_AW(SW)) dut (
        .Clk        (clk),
        .Resetn     (rst_n),
        .Start      (start),
        .Abort      (abort),
        .Busy       (busy),
        .Done       (done),
        .RomAddr    (rom_addr),
        .RomDoutA   (rom_a),
        .RomDoutB   (rom_b),
        .SampRdAddr (rd_addr),
        .SampRdData (rd_data),
        .FftWrEn    (wr_en),
        .FftWrAddr  (wr_addr),
        .FftWrData  (wr_data)
    );

    function automatic logic [9:0] bitrev10(input logic [9:0] x);
        logic [9:0] r;
        for (int i = 0; i < 10; i++) r[i] = x[9-i];
        return r;
    endfunction

    logic [DW-1:0] mem [1024];

    always @(posedge clk) begin
        rom_a   <= bitrev10({rom_addr, 1'b0});
        rom_b   <= bitrev10({rom_addr, 1'b1});
        rd_data <= mem[rd_addr];
    end

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int e0 = 0;
    int nwr = 0;
    logic [25:0] sb[$];
    int done_q[$];
    logic [25:0] mon_exp;
    logic [DW-1:0] w1data;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (wr_en === 1'b1) begin
            nwr++;
            checks++;
            if (wr_addr == 10'd1) w1data = wr_data;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL sb_extra: got addr %0d data %h, required no write",
                         wr_addr, wr_data);
            end else begin
                mon_exp = sb.pop_front();
                if ({wr_addr, wr_data} !== mon_exp) begin
                    errors++;
                    $display("FAIL sb_write: got addr %0d data %h, required addr %0d data %h",
                             wr_addr, wr_data, mon_exp[25:16], mon_exp[15:0]);
                end
            end
        end
        if (done === 1'b1) done_q.push_back(cyc - e0 + 1);
    end

    task automatic clear_stats();
        sb.delete();
        done_q.delete();
        nwr = 0;
        w1data = '0;
    endtask

    task automatic fill_mem(input bit inverted);
        for (int i = 0; i < 1024; i++)
            mem[i] = inverted ? 16'(16'hFFFF - i) : 16'(i);
    endtask

    task automatic push_pairs(input int npairs);
        logic [9:0] av;
        for (int a = 0; a < 2 * npairs; a++) begin
            av = a[9:0];
            sb.push_back({av, mem[bitrev10(av)]});
        end
    endtask

    task automatic begin_frame(input bit hold);
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1 e0 = cyc;
        start = hold;
    endtask

    // run up to the falling edge inside cycle `last` (cycle 1 follows e0)
    task automatic run_to(input int last, input int p1, input int p2,
                          input int ab, input bit hold);
        int n;
        forever begin
            @(negedge clk);
            n = cyc - e0 + 1;
            start = hold || (n == p1) || (n == p2);
            abort = (n == ab);
            if (n >= last) break;
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        start = 1'b0;
        abort = 1'b0;
        #1;
        checks++;
        if ({busy, done, wr_en, rom_addr, rd_addr, wr_addr, wr_data} !== '0) begin
            errors++;
            $display("FAIL reset_outputs: got busy %b done %b we %b rom %0d rd %0d wa %0d wd %h, required all 0",
                     busy, done, wr_en, rom_addr, rd_addr, wr_addr, wr_data);
        end
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_idle_busy: got %b required 0", busy);
        end
    endtask

    task automatic test_full_frame();
        clear_stats();
        fill_mem(1'b0);
        push_pairs(512);
        begin_frame(1'b0);
        run_to(2049, -1, -1, -1, 1'b0);
        checks++;
        if ({done, busy} !== 2'b11) begin
            errors++;
            $display("FAIL full_done_2049: got done %b busy %b, required 1 1", done, busy);
        end
        run_to(2050, -1, -1, -1, 1'b0);
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL full_busy_2050: got %b required 0", busy);
        end
        checks++;
        if (nwr != 1024 || sb.size() != 0) begin
            errors++;
            $display("FAIL full_count: got %0d writes %0d pending, required 1024 0", nwr, sb.size());
        end
        checks++;
        if (done_q.size() != 1 || done_q[0] != 2049) begin
            errors++;
            $display("FAIL full_done_pulse: got %0d pulses first %0d, required 1 at 2049",
                     done_q.size(), done_q.size() > 0 ? done_q[0] : -1);
        end
    endtask

    task automatic test_start_ignored();
        clear_stats();
        fill_mem(1'b0);
        push_pairs(512);
        begin_frame(1'b0);
        run_to(2056, 100, 2049, -1, 1'b0);
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL ign_restart: got busy %b required 0", busy);
        end
        checks++;
        if (nwr != 1024 || sb.size() != 0 || done_q.size() != 1) begin
            errors++;
            $display("FAIL ign_count: got %0d writes %0d dones, required 1024 1", nwr, done_q.size());
        end
    endtask

    task automatic test_abort();
        clear_stats();
        fill_mem(1'b0);
        push_pairs(5);
        sb.push_back({10'd10, mem[bitrev10(10'd10)]});
        begin_frame(1'b0);
        run_to(23, -1, -1, 23, 1'b0);
        run_to(24, -1, -1, -1, 1'b0);
        checks++;
        if ({busy, wr_en} !== 2'b00) begin
            errors++;
            $display("FAIL abort_next: got busy %b we %b, required 0 0", busy, wr_en);
        end
        run_to(60, -1, -1, -1, 1'b0);
        checks++;
        if (nwr != 11 || sb.size() != 0 || done_q.size() != 0) begin
            errors++;
            $display("FAIL abort_count: got %0d writes %0d dones, required 11 0", nwr, done_q.size());
        end
    endtask

    task automatic test_async_reset();
        clear_stats();
        fill_mem(1'b0);
        push_pairs(300);
        begin_frame(1'b0);
        run_to(1202, -1, -1, -1, 1'b0);
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if ({busy, done, wr_en, rom_addr, rd_addr, wr_addr, wr_data} !== '0) begin
            errors++;
            $display("FAIL areset_outputs: got busy %b done %b we %b rom %0d rd %0d wa %0d wd %h, required all 0",
                     busy, done, wr_en, rom_addr, rd_addr, wr_addr, wr_data);
        end
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (10) @(negedge clk);
        checks++;
        if (busy !== 1'b0 || nwr != 600 || sb.size() != 0 || done_q.size() != 0) begin
            errors++;
            $display("FAIL areset_after: got busy %b writes %0d dones %0d, required 0 600 0",
                     busy, nwr, done_q.size());
        end
    endtask

    task automatic test_back_to_back();
        clear_stats();
        fill_mem(1'b0);
        push_pairs(512);
        push_pairs(512);
        begin_frame(1'b1);
        run_to(2050, -1, -1, -1, 1'b1);
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL b2b_idle_2050: got busy %b required 0", busy);
        end
        run_to(2051, -1, -1, -1, 1'b1);
        checks++;
        if (busy !== 1'b1 || rom_addr !== '0) begin
            errors++;
            $display("FAIL b2b_rom_2051: got busy %b rom %0d, required 1 0", busy, rom_addr);
        end
        run_to(4099, -1, -1, -1, 1'b1);
        run_to(4106, -1, -1, -1, 1'b0);
        checks++;
        if (nwr != 2048 || sb.size() != 0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL b2b_count: got %0d writes busy %b, required 2048 0", nwr, busy);
        end
        checks++;
        if (done_q.size() != 2 || done_q[0] != 2049 || done_q[1] != 4099) begin
            errors++;
            $display("FAIL b2b_done: got %0d pulses, required 2 at 2049 and 4099", done_q.size());
        end
    endtask

    task automatic test_data_width();
        clear_stats();
        fill_mem(1'b1);
        push_pairs(512);
        begin_frame(1'b0);
        run_to(2052, -1, -1, -1, 1'b0);
        checks++;
        if (w1data !== 16'hFDFF) begin
            errors++;
            $display("FAIL width_addr1: got %h required fdff", w1data);
        end
        checks++;
        if (nwr != 1024 || sb.size() != 0) begin
            errors++;
            $display("FAIL width_count: got %0d writes required 1024", nwr);
        end
    endtask

    initial begin
        test_reset();
        test_full_frame();
        test_start_ignored();
        test_abort();
        test_full_frame();
        test_async_reset();
        test_full_frame();
        test_back_to_back();
        test_data_width();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/fft_bitrev_loader.md
Name: fft_bitrev_loader

Overview:
- Sequencer that reorders one 1024-sample frame into bit-reversed order for the radix-2 FFT core.
- Steps the bit-reversal ROM through addresses 0..511 and reads the sample buffer at the two returned addresses.
- Writes the fetched samples sequentially into FFT working RAM.
- Sits between the sample capture buffer / bit-reversal ROM and the FFT butterfly engine.

Parameters:
DATA_W, 16, sample width
ROM_AW, 9, bit-reversal ROM address width (512 pairs)
SAMP_AW, 10, sample/FFT RAM address width (1024 points)

Ports:
Clk  in  1  system clock, rising edge
Resetn  in  1  asynchronous active-low reset
Start  in  1  begin frame load; sampled only in IDLE
Abort  in  1  synchronous abort; returns to IDLE
Busy  out  1  high from first cycle after accepted Start through DONE cycle
Done  out  1  one-cycle pulse after last write
RomAddr  out  ROM_AW  bit-reversal ROM address (registered pair index k)
RomDoutA  in  SAMP_AW  ROM output A: bitrev10(2k), valid 1 cycle after RomAddr
RomDoutB  in  SAMP_AW  ROM output B: bitrev10(2k+1), same timing
SampRdAddr  out  SAMP_AW  sample buffer read address
SampRdData  in  DATA_W  sample buffer data, valid 1 cycle after SampRdAddr (sync read)
FftWrEn  out  1  FFT RAM write enable
FftWrAddr  out  SAMP_AW  FFT RAM write address
FftWrData  out  DATA_W  FFT RAM write data

Behaviour:
- Reset (async, Resetn=0): state IDLE, k=0, regB=0; Busy=0, Done=0, FftWrEn=0, RomAddr=0, SampRdAddr=0, FftWrAddr=0, FftWrData=0. Takes effect immediately, mid-frame included; no further writes occur.
- States: IDLE, ROM, SELA, SELB, WRB, DONE. Four cycles per pair.
- IDLE: Start=1 at a clock edge -> ROM, k=0. Otherwise remain in IDLE.
- ROM: RomAddr=k. ROM samples the address at the end of this cycle. -> SELA.
- SELA: RomDoutA/B valid. SampRdAddr=RomDoutA (combinational). regB<=RomDoutB. -> SELB.
- SELB: SampRdAddr=regB. FftWrEn=1, FftWrAddr={k,1'b0}, FftWrData=SampRdData (= sample[A]). -> WRB.
- WRB: FftWrEn=1, FftWrAddr={k,1'b1}, FftWrData=SampRdData (= sample[B]).
  - If k==511 -> DONE.
  - Else k<=k+1 -> ROM.
- DONE: Done=1, Busy=1, FftWrEn=0. -> IDLE unconditionally.
- In all other states FftWrEn=0.
- Timing from accepting edge e0:
  - Pair k occupies cycles 4k+1..4k+4.
  - Writes occur in cycles 4k+3 and 4k+4.
  - DONE is cycle 2049; IDLE at cycle 2050.
  - Busy=1 in cycles 1..2049.
- Exactly 1024 writes per frame, addresses 0..1023 ascending, each address written exactly once.
- Start while not in IDLE: ignored, no restart.
- Start held high: a new frame begins on the edge after DONE (IDLE lasts one cycle).
- Abort=1 in any non-IDLE state: next state IDLE, k=0, FftWrEn=0 from the next cycle, no Done pulse.
  - Abort has priority over all transitions, including WRB->DONE.
  - Abort in IDLE is a no-op.
  - Abort and Start together in IDLE: Abort wins, frame not started.
- k counter is ROM_AW bits. Its terminal compare is k==511, so it never wraps inside a frame.
- SampRdAddr holds its last value outside SELA/SELB. Verification must not check it there.

Test Plan:
- Full frame with sample[i]=i and a ROM model returning bitrev10(2k)/bitrev10(2k+1) -> FftWr sequence (addr,data) = (0,0),(1,512),(2,256),(3,768),…,(1023,1023). Every write data equals bitrev10(addr). Exactly 1024 FftWrEn cycles. Done pulses once at cycle 2049 after Start. Busy falls at cycle 2050.
- Start pulsed again at cycles 100 and 2049 of a running frame -> ignored. Write count stays 1024, Done pulses once.
- Abort asserted during SELB of pair 5 -> write to addr 10 happens in that cycle. No write to addr 11 or later. Busy=0 next cycle, Done never pulses. A subsequent Start produces a complete, correct frame from addr 0.
- Resetn driven low asynchronously between edges during pair 300 -> all outputs 0 immediately. After release, stays IDLE until Start. Next frame is correct.
- Start held high continuously -> two back-to-back frames. Second frame's ROM state occurs at cycle 2051. Each frame has 1024 correct writes and its own Done pulse.
- Sample buffer with sample[i]=16'hFFFF-i -> write at addr 1 carries 16'hFDFF. Confirms full DATA_W data path with no truncation.
